// File: rtl/carry_chain_pipe.sv
// Pipelined wide carry chain: NSEG 8-bit carry-mux segments, register boundary every
// SEG_PER_STAGE segments, input skew/output deskew. Define CARRY_PIPE_OVF_EN to add OVF.

module carry_seg #(
   parameter int SW = 8
) (
   input  logic          ci,
   input  logic [SW-1:0] di,
   input  logic [SW-1:0] s,
   output logic [SW-1:0] co,
   output logic [SW-1:0] o
);
   always_comb begin
      logic c;
      c  = ci;
      co = '0;
      o  = '0;
      for (int i = 0; i < SW; i++) begin
         o[i]  = s[i] ^ c;
         c     = s[i] ? c : di[i];
         co[i] = c;
      end
   end
endmodule

module carry_chain_pipe #(
   parameter int NSEG          = 4,
   parameter int SEG_PER_STAGE = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CE,
   input  logic              IN_VLD,
   input  logic              CI,
   input  logic [8*NSEG-1:0] DI,
   input  logic [8*NSEG-1:0] S,
   output logic              OUT_VLD,
   output logic [8*NSEG-1:0] CO,
   output logic [8*NSEG-1:0] O,
   output logic              CO_OUT
`ifdef CARRY_PIPE_OVF_EN
   ,
   output logic              OVF
`endif
);
   localparam int SW   = 8 * SEG_PER_STAGE;
   localparam int NSTG = NSEG / SEG_PER_STAGE;

   logic [NSTG:1]              vld_pipe;
   logic [NSTG-1:0][SW-1:0]    co_q, o_q;

   always_ff @(posedge CLK) begin
      if (RST) vld_pipe <= '0;
      else if (CE) begin
         vld_pipe[1] <= IN_VLD;
         for (int k = 2; k <= NSTG; k++) vld_pipe[k] <= vld_pipe[k-1];
      end
   end

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      localparam int D = NSTG - k;
      logic [SW-1:0]        di_e, s_e, co_c, o_c;
      logic                 ci_e;
      logic [D-1:0][SW-1:0] co_p, o_p;

      if (k == 0) begin : g_in
         assign di_e = DI[0 +: SW];
         assign s_e  = S[0 +: SW];
         assign ci_e = CI;
      end else begin : g_skew
         // k skew levels line this slice up with the registered carry of stage k-1
         logic [k-1:0][SW-1:0] di_p, s_p;
         always_ff @(posedge CLK) begin
            if (RST) begin
               di_p <= '0;
               s_p  <= '0;
            end else if (CE) begin
               di_p[0] <= DI[k*SW +: SW];
               s_p[0]  <= S[k*SW +: SW];
               for (int j = 1; j < k; j++) begin
                  di_p[j] <= di_p[j-1];
                  s_p[j]  <= s_p[j-1];
               end
            end
         end
         assign di_e = di_p[k-1];
         assign s_e  = s_p[k-1];
         assign ci_e = g_stg[k-1].co_p[0][SW-1];
      end

      carry_seg #(.SW(SW)) u_seg (
         .ci (ci_e),
         .di (di_e),
         .s  (s_e),
         .co (co_c),
         .o  (o_c)
      );

      // co_p[0] is the stage result register; the rest is deskew
      always_ff @(posedge CLK) begin
         if (RST) begin
            co_p <= '0;
            o_p  <= '0;
         end else if (CE) begin
            co_p[0] <= co_c;
            o_p[0]  <= o_c;
            for (int j = 1; j < D; j++) begin
               co_p[j] <= co_p[j-1];
               o_p[j]  <= o_p[j-1];
            end
         end
      end

      assign co_q[k] = co_p[D-1];
      assign o_q[k]  = o_p[D-1];
   end

   assign OUT_VLD = vld_pipe[NSTG];
   assign CO      = co_q;
   assign O       = o_q;
   assign CO_OUT  = co_q[NSTG-1][SW-1];

`ifdef CARRY_PIPE_OVF_EN
   logic ovf_r;
   always_ff @(posedge CLK) begin
      if (RST) ovf_r <= 1'b0;
      else if (CE) ovf_r <= g_stg[NSTG-1].co_c[SW-1] ^ g_stg[NSTG-1].co_c[SW-2];
   end
   assign OVF = ovf_r;
`endif
endmodule
